// File: rtl/lsu_axi_master_pkg.sv
// Shared types and constants for the load/store unit bus front-end.
package lsu_axi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AWW,
    ST_B,
    ST_RESP
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  // Size code 3 is never legal, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    case (size)
      SIZE_B:  is_misaligned = 1'b0;
      SIZE_H:  is_misaligned = addr_lo[0];
      SIZE_W:  is_misaligned = (addr_lo != 2'd0);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_axi_master_data_align.sv
// Byte-lane steering for stores, field extraction/extension for loads,
// and the alignment check shared by the request path.
module lsu_data_align
  import lsu_axi_master_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          addr_lo,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  input  logic [DATA_W-1:0]   store_data,
  input  logic [DATA_W-1:0]   read_data,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   load_data,
  output logic                misaligned
);

  logic [4:0]          shamt;
  logic [3:0]          strb_base;
  logic [DATA_W-1:0]   sh;

  always_comb begin
    shamt = {addr_lo, 3'b000};
    wdata = store_data << shamt;
    case (size)
      SIZE_B:  strb_base = 4'b0001;
      SIZE_H:  strb_base = 4'b0011;
      SIZE_W:  strb_base = 4'b1111;
      default: strb_base = 4'b0000;
    endcase
    wstrb = strb_base << addr_lo;

    sh = read_data >> shamt;
    case (size)
      SIZE_B:  load_data = {{24{~is_unsigned & sh[7]}}, sh[7:0]};
      SIZE_H:  load_data = {{16{~is_unsigned & sh[15]}}, sh[15:0]};
      default: load_data = sh;
    endcase

    misaligned = is_misaligned(addr_lo, size);
  end

endmodule

// File: rtl/lsu_axi_master.sv
// Blocking load/store front-end: one core request becomes one AXI4-Lite
// read or write transaction, answered by a single-cycle response pulse.
module lsu_axi_master
  import lsu_axi_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  output logic                bready,
  input  logic [1:0]          bresp,
  input  logic                bvalid
);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [1:0]          size_reg, size_next;
  logic                unsigned_reg, unsigned_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                err_reg, err_next;
  logic                aw_done_reg, aw_done_next;
  logic                w_done_reg, w_done_next;

  logic [1:0]          align_addr;
  logic [1:0]          align_size;
  logic [DATA_W-1:0]   align_wdata;
  logic [DATA_W/8-1:0] align_wstrb;
  logic [DATA_W-1:0]   align_load;
  logic                align_misaligned;
  logic                aw_hs;
  logic                w_hs;

  // In IDLE the aligner checks the incoming request; afterwards it works
  // on the latched one.
  assign align_addr = (state_reg == ST_IDLE) ? req_addr[1:0] : addr_reg[1:0];
  assign align_size = (state_reg == ST_IDLE) ? req_size : size_reg;

  lsu_data_align #(.DATA_W(DATA_W)) u_align (
    .addr_lo     (align_addr),
    .size        (align_size),
    .is_unsigned (unsigned_reg),
    .store_data  (wdata_reg),
    .read_data   (rdata),
    .wdata       (align_wdata),
    .wstrb       (align_wstrb),
    .load_data   (align_load),
    .misaligned  (align_misaligned)
  );

  assign aw_hs = (state_reg == ST_AWW) && !aw_done_reg && awready;
  assign w_hs  = (state_reg == ST_AWW) && !w_done_reg && wready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      size_reg     <= '0;
      unsigned_reg <= 1'b0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      size_reg     <= size_next;
      unsigned_reg <= unsigned_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      err_reg      <= err_next;
      aw_done_reg  <= aw_done_next;
      w_done_reg   <= w_done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    size_next     = size_reg;
    unsigned_next = unsigned_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    err_next      = err_reg;
    aw_done_next  = aw_done_reg;
    w_done_next   = w_done_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          addr_next     = req_addr;
          size_next     = req_size;
          unsigned_next = req_unsigned;
          wdata_next    = req_wdata;
          rdata_next    = '0;
          err_next      = align_misaligned;
          aw_done_next  = 1'b0;
          w_done_next   = 1'b0;
          if (align_misaligned) state_next = ST_RESP;
          else if (req_wen)     state_next = ST_AWW;
          else                  state_next = ST_AR;
        end
      end
      ST_AR: if (arready) state_next = ST_R;
      ST_R: begin
        if (rvalid) begin
          err_next   = (rresp != OKAY);
          rdata_next = (rresp != OKAY) ? '0 : align_load;
          state_next = ST_RESP;
        end
      end
      ST_AWW: begin
        aw_done_next = aw_done_reg | aw_hs;
        w_done_next  = w_done_reg | w_hs;
        if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) state_next = ST_B;
      end
      ST_B: begin
        if (bvalid) begin
          err_next   = (bresp != OKAY);
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    araddr     = '0;
    arsize     = '0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awaddr     = '0;
    awsize     = '0;
    awvalid    = 1'b0;
    wdata      = '0;
    wstrb      = '0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    case (state_reg)
      ST_IDLE: req_ready = 1'b1;
      ST_AR: begin
        arvalid = 1'b1;
        araddr  = addr_reg;
        arsize  = {1'b0, size_reg};
      end
      ST_R: rready = 1'b1;
      ST_AWW: begin
        awvalid = !aw_done_reg;
        wvalid  = !w_done_reg;
        awaddr  = addr_reg;
        awsize  = {1'b0, size_reg};
        wdata   = align_wdata;
        wstrb   = align_wstrb;
      end
      ST_B: bready = 1'b1;
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_reg;
        resp_err   = err_reg;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master with a configurable-latency AXI4-Lite slave.
module tb_lsu_axi_master;
  import lsu_axi_master_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rready, rvalid, awvalid, awready, wvalid, wready, bready, bvalid;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  always #5 clock = ~clock;

  lsu_axi_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rready(rready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bready(bready), .bresp(bresp), .bvalid(bvalid)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Slave configuration, written only by the stimulus process.
  int          ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
  logic [31:0] r_data_v = '0;
  logic [1:0]  r_resp_v = 2'd0, b_resp_v = 2'd0;

  int   ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
  logic r_pend, b_pend, aw_got, w_got;

  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign rvalid  = r_pend && (r_cnt >= r_dly);
  assign bvalid  = b_pend && (b_cnt >= b_dly);
  assign rdata   = r_data_v;
  assign rresp   = r_resp_v;
  assign bresp   = b_resp_v;

  always @(posedge clock) begin
    if (reset) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
      r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
    end else begin
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (arvalid && arready) begin
        r_pend <= 1'b1; r_cnt <= 0;
      end else if (r_pend) begin
        if (rvalid && rready) r_pend <= 1'b0;
        else r_cnt <= r_cnt + 1;
      end
      if (b_pend) begin
        if (bvalid && bready) b_pend <= 1'b0;
        else b_cnt <= b_cnt + 1;
      end
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (awvalid && awready) aw_got <= 1'b1;
        if (wvalid && wready) w_got <= 1'b1;
      end
    end
  end

  // Bus monitor: counts valid-high cycles and handshakes, captures payloads.
  int          ar_hi = 0, aw_hi = 0, w_hi = 0, b_hs = 0, resp_cnt = 0;
  logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
  logic [2:0]  cap_arsize = '0, cap_awsize = '0;
  logic [3:0]  cap_wstrb = '0;

  always @(negedge clock) begin
    if (arvalid) ar_hi <= ar_hi + 1;
    if (awvalid) aw_hi <= aw_hi + 1;
    if (wvalid) w_hi <= w_hi + 1;
    if (arvalid && arready) begin cap_araddr <= araddr; cap_arsize <= arsize; end
    if (awvalid && awready) begin cap_awaddr <= awaddr; cap_awsize <= awsize; end
    if (wvalid && wready) begin cap_wdata <= wdata; cap_wstrb <= wstrb; end
    if (bvalid && bready) b_hs <= b_hs + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request and wait for its response; lat is response cycle minus accept cycle.
  task automatic run_req(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat);
    int  acc;
    bit  got;
    rd = '0; err = 1'b0; lat = -1; acc = 0;
    @(posedge clock); #1;
    req_wen = wen; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (req_ready) begin got = 1'b1; acc = cyc; end
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL accept_timeout: req_ready never seen for addr %h", addr);
      return;
    end
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clock);
      if (resp_valid) begin got = 1'b1; rd = resp_rdata; err = resp_err; lat = cyc - acc; end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL resp_timeout: resp_valid never seen for addr %h", addr);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    tests++;
    if ({arvalid, awvalid, wvalid, rready, bready, resp_valid} !== 6'b0) begin
      fails++; $display("FAIL reset_valids: got %b expected 000000", {arvalid, awvalid, wvalid, rready, bready, resp_valid});
    end
    tests++;
    if ({araddr, awaddr, wdata, wstrb, arsize, awsize} !== '0) begin
      fails++; $display("FAIL reset_buses: got araddr %h awaddr %h wdata %h wstrb %b expected all 0", araddr, awaddr, wdata, wstrb);
    end
    tests++;
    if ({resp_rdata, resp_err} !== '0) begin
      fails++; $display("FAIL reset_resp: got rdata %h err %b expected 0/0", resp_rdata, resp_err);
    end
  endtask

  task automatic test_load();
    logic [31:0] rd; logic err; int lat;
    r_data_v = 32'h80AA_BBCC; r_resp_v = OKAY;
    run_req(1'b0, 32'h8000_0003, SIZE_B, 1'b0, 32'h0, rd, err, lat);
    tests++; if (cap_araddr !== 32'h8000_0003) begin fails++; $display("FAIL ldb_araddr: got %h expected 80000003", cap_araddr); end
    tests++; if (cap_arsize !== 3'd0) begin fails++; $display("FAIL ldb_arsize: got %0d expected 0", cap_arsize); end
    tests++; if (rd !== 32'hFFFF_FF80) begin fails++; $display("FAIL ldb_rdata: got %h expected ffffff80", rd); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL ldb_err: got %b expected 0", err); end
    tests++; if (lat != 3) begin fails++; $display("FAIL ldb_latency: got %0d expected 3", lat); end
    run_req(1'b0, 32'h8000_0002, SIZE_H, 1'b1, 32'h0, rd, err, lat);
    tests++; if (rd !== 32'h0000_80AA) begin fails++; $display("FAIL ldhu_rdata: got %h expected 000080aa", rd); end
    tests++; if (cap_arsize !== 3'd1) begin fails++; $display("FAIL ldhu_arsize: got %0d expected 1", cap_arsize); end
    r_data_v = 32'h1234_F00D;
    run_req(1'b0, 32'h0000_0040, SIZE_H, 1'b0, 32'h0, rd, err, lat);
    tests++; if (rd !== 32'hFFFF_F00D) begin fails++; $display("FAIL ldh_rdata: got %h expected fffff00d", rd); end
    run_req(1'b0, 32'h0000_0041, SIZE_B, 1'b1, 32'h0, rd, err, lat);
    tests++; if (rd !== 32'h0000_00F0) begin fails++; $display("FAIL ldbu_rdata: got %h expected 000000f0", rd); end
    r_data_v = 32'h8000_0001;
    run_req(1'b0, 32'h0000_0104, SIZE_W, 1'b0, 32'h0, rd, err, lat);
    tests++; if (rd !== 32'h8000_0001) begin fails++; $display("FAIL ldw_rdata: got %h expected 80000001", rd); end
    tests++; if (cap_arsize !== 3'd2) begin fails++; $display("FAIL ldw_arsize: got %0d expected 2", cap_arsize); end
  endtask

  task automatic test_store();
    logic [31:0] rd; logic err; int lat;
    b_resp_v = OKAY;
    run_req(1'b1, 32'h8000_0002, SIZE_H, 1'b0, 32'h0000_1234, rd, err, lat);
    tests++; if (cap_wstrb !== 4'b1100) begin fails++; $display("FAIL sth_wstrb: got %b expected 1100", cap_wstrb); end
    tests++; if (cap_wdata !== 32'h1234_0000) begin fails++; $display("FAIL sth_wdata: got %h expected 12340000", cap_wdata); end
    tests++; if (cap_awsize !== 3'd1) begin fails++; $display("FAIL sth_awsize: got %0d expected 1", cap_awsize); end
    tests++; if (cap_awaddr !== 32'h8000_0002) begin fails++; $display("FAIL sth_awaddr: got %h expected 80000002", cap_awaddr); end
    tests++; if ({rd, err} !== 33'h0) begin fails++; $display("FAIL sth_resp: got rdata %h err %b expected 0/0", rd, err); end
    run_req(1'b1, 32'h0000_0201, SIZE_B, 1'b0, 32'hFFFF_FFAB, rd, err, lat);
    tests++; if (cap_wstrb !== 4'b0010) begin fails++; $display("FAIL stb_wstrb: got %b expected 0010", cap_wstrb); end
    tests++; if (cap_wdata !== 32'hFFFF_AB00) begin fails++; $display("FAIL stb_wdata: got %h expected ffffab00", cap_wdata); end
    b_resp_v = DECERR;
    run_req(1'b1, 32'h0000_0300, SIZE_W, 1'b0, 32'hCAFE_0001, rd, err, lat);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL stw_bresp_err: got %b expected 1", err); end
    b_resp_v = OKAY;
  endtask

  task automatic test_aw_before_w();
    logic [31:0] rd; logic err; int lat;
    int aw0, w0, b0, r0;
    w_dly = 3;
    aw0 = aw_hi; w0 = w_hi; b0 = b_hs; r0 = resp_cnt;
    run_req(1'b1, 32'h8000_0010, SIZE_W, 1'b0, 32'hDEAD_BEEF, rd, err, lat);
    tests++; if (aw_hi - aw0 != 1) begin fails++; $display("FAIL split_awvalid_cycles: got %0d expected 1", aw_hi - aw0); end
    tests++; if (w_hi - w0 != 4) begin fails++; $display("FAIL split_wvalid_cycles: got %0d expected 4", w_hi - w0); end
    tests++; if (b_hs - b0 != 1) begin fails++; $display("FAIL split_b_handshakes: got %0d expected 1", b_hs - b0); end
    tests++; if (resp_cnt - r0 != 1) begin fails++; $display("FAIL split_resp_count: got %0d expected 1", resp_cnt - r0); end
    tests++; if (cap_wdata !== 32'hDEAD_BEEF || cap_wstrb !== 4'b1111) begin
      fails++; $display("FAIL split_wpayload: got %h/%b expected deadbeef/1111", cap_wdata, cap_wstrb);
    end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL split_err: got %b expected 0", err); end
    w_dly = 0;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic err; int lat;
    int ar0, aw0, w0;
    r_data_v = 32'h5555_5555;
    ar0 = ar_hi; aw0 = aw_hi; w0 = w_hi;
    run_req(1'b0, 32'h8000_0001, SIZE_W, 1'b0, 32'h0, rd, err, lat);
    tests++; if (ar_hi != ar0 || aw_hi != aw0) begin fails++; $display("FAIL mis_ldw_bus: got arvalid cycles %0d awvalid cycles %0d expected 0/0", ar_hi - ar0, aw_hi - aw0); end
    tests++; if (lat != 1) begin fails++; $display("FAIL mis_ldw_latency: got %0d expected 1", lat); end
    tests++; if (err !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL mis_ldw_resp: got err %b rdata %h expected 1/0", err, rd); end
    run_req(1'b1, 32'h0000_0011, SIZE_H, 1'b0, 32'h1111_2222, rd, err, lat);
    tests++; if (aw_hi != aw0 || w_hi != w0 || err !== 1'b1) begin fails++; $display("FAIL mis_sth: got awvalid cycles %0d err %b expected 0/1", aw_hi - aw0, err); end
    run_req(1'b0, 32'h0000_0020, 2'd3, 1'b0, 32'h0, rd, err, lat);
    tests++; if (ar_hi != ar0 || err !== 1'b1 || lat != 1) begin fails++; $display("FAIL illegal_size: got arvalid cycles %0d err %b lat %0d expected 0/1/1", ar_hi - ar0, err, lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd1, rd2; logic err1, err2;
    int resp1, acc2;
    bit got;
    rd1 = '0; rd2 = '0; err1 = 1'b0; err2 = 1'b0; resp1 = 0; acc2 = -100;
    r_data_v = 32'h1122_3344; r_resp_v = SLVERR;
    @(posedge clock); #1;
    req_wen = 1'b0; req_addr = 32'h0000_0100; req_size = SIZE_W; req_unsigned = 1'b0; req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clock); if (req_ready) got = 1'b1; end
    @(posedge clock); #1;
    req_addr = 32'h0000_0101; req_size = SIZE_B; req_unsigned = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (resp_valid) begin got = 1'b1; rd1 = resp_rdata; err1 = resp_err; resp1 = cyc; end
    end
    r_resp_v = OKAY;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clock); if (req_ready) begin got = 1'b1; acc2 = cyc; end end
    @(posedge clock); #1;
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (resp_valid) begin got = 1'b1; rd2 = resp_rdata; err2 = resp_err; end
    end
    tests++; if (err1 !== 1'b1 || rd1 !== 32'h0) begin fails++; $display("FAIL rresp_err: got err %b rdata %h expected 1/0", err1, rd1); end
    tests++; if (acc2 - resp1 != 1) begin fails++; $display("FAIL b2b_accept_gap: got %0d expected 1", acc2 - resp1); end
    tests++; if (rd2 !== 32'h0000_0033 || err2 !== 1'b0) begin fails++; $display("FAIL b2b_second_resp: got %h/%b expected 00000033/0", rd2, err2); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int lat;
    int r0;
    bit got;
    r_dly = 30; r_data_v = 32'h0000_00AB;
    @(posedge clock); #1;
    req_wen = 1'b0; req_addr = 32'h0000_0200; req_size = SIZE_W; req_unsigned = 1'b0; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clock); if (rready) got = 1'b1; end
    tests++; if (!got) begin fails++; $display("FAIL midrst_reach_r: rready not seen, got 0 expected 1"); end
    r0 = resp_cnt;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if ({arvalid, rready, req_ready, resp_valid} !== 4'b0010) begin
      fails++; $display("FAIL midrst_outputs: got arvalid/rready/req_ready/resp_valid %b expected 0010", {arvalid, rready, req_ready, resp_valid});
    end
    repeat (40) @(negedge clock);
    tests++; if (resp_cnt != r0) begin fails++; $display("FAIL midrst_no_resp: got %0d responses expected 0", resp_cnt - r0); end
    r_dly = 0;
    run_req(1'b0, 32'h0000_0200, SIZE_W, 1'b0, 32'h0, rd, err, lat);
    tests++; if (rd !== 32'h0000_00AB || err !== 1'b0) begin fails++; $display("FAIL midrst_recover: got %h/%b expected 000000ab/0", rd, err); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_aw_before_w();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
